fifo4x32_hs: RTL and testbench
==============================

# fifo4x32_hs

Four-entry, 32-bit synchronous FIFO with valid/ready handshakes on both ends. It decouples a producing pipeline stage (write side) from a consuming stage (read side), so a stall on the consumer does not drop data already issued by the producer. It is placed between adjacent pipeline latches wherever a stage needs elastic buffering, for example fetch-to-decode. It has a single clock domain.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 4: number of entries. Must be a power of two; only 4 is verified.
- clk  input  1  clock. All state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-low. It clears all state immediately on assertion and takes effect regardless of clk.
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  producer has data on in_data.
- in_ready  output  1  FIFO can accept data (equal to !full).
- in_data  input  WIDTH  write data.
- out_valid  output  1  head entry is valid (equal to !empty).
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  WIDTH  head entry.
- count  output  3  number of occupied entries, 0–4.
- full  output  1  count == 4.
- empty  output  1  count == 0.

## Operation
- push = in_valid & in_ready. pop = out_valid & out_ready.
- On push, in_data is written to mem[wr_ptr] and wr_ptr increments.
- On pop, rd_ptr increments. out_data always reflects mem[rd_ptr].
- Pointers are 2 bits wide and wrap from 3 to 0 naturally, with no extra logic.
- count changes by +1 on push only, by −1 on pop only, and is unchanged on push and pop together.
- Simultaneous push and pop when count is 1–3: both happen, and count is unchanged.
- Full: in_ready=0, so a push cannot occur even if a pop occurs in the same cycle. There is no pass-through when full; this is deliberate and keeps in_ready free of any dependence on out_ready.
- Empty: out_valid=0, so pop is impossible. There is no bypass: data pushed into an empty FIFO appears on out_valid/out_data one cycle later.
- flush has priority over push and pop. On the next edge, wr_ptr, rd_ptr and count are all set to 0, and any concurrent push or pop is ignored. Memory contents are not cleared.
- Reset (clr=0): wr_ptr=0, rd_ptr=0, count=0. Memory is not reset.
- Reset mid-operation discards all entries. The first push after clr deasserts lands in entry 0.
- While count=0, out_data is don't-care. The bench must not check it.

## Timing
- Reset values of outputs: in_ready=1, out_valid=0, full=0, empty=1, count=0, out_data=X.
- Write-to-read latency is 1 cycle: a push at edge N gives out_valid=1 after edge N.
- in_ready, out_valid, full, empty and count are decoded directly from the count register. They have no combinational path from in_valid or out_ready.
- out_data is a combinational read mux from the memory and rd_ptr registers.
- Throughput is one push and one pop per cycle in steady state when count is 1–3.
- The producer must hold in_data stable while in_valid=1 and in_ready=0. in_valid may drop without an accepted transfer.

## Structure
- Shared package:
  - FIFO_DEPTH=4 and FIFO_PTR_W=2.
  - FIFO_CNT_W=3, the width of count.
  - Default WIDTH=32.
- Storage is DEPTH x WIDTH registers, enabled per entry by the decoded wr_ptr AND push.
- Read is a 4:1 WIDTH-bit mux on rd_ptr.
- Natural sub-module: fifo_ptr_ctrl. It holds wr_ptr, rd_ptr and count, takes push, pop and flush, and produces full, empty and the write-enable decode. The datapath stays in the top level.
- The read mux and write-enable decode use the team's existing gate library cells: the 32-bit AND/OR/NOT arrays and the wide AND/OR gates.

## Test plan
- Reset and idle: clr low then high, no traffic. Expect count=0, empty=1, in_ready=1, out_valid=0 for 10 cycles.
- Fill and drain: push 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_ready=0.
  - Expect full=1, in_ready=0, count=4.
  - A fifth in_valid with 0x55555555 is not accepted.
  - Then out_ready=1: pops return 0x11111111 through 0x44444444 in order, and empty=1 after 4 pops.
- Wrap-around: 10 cycles with in_valid=1 and out_ready=1 carrying an incrementing pattern 0x0 to 0x9, after a single preload of 0xA5A5A5A5.
  - count stays at 1.
  - Outputs are 0xA5A5A5A5, 0x0, 0x1, … in order across the pointer wrap.
- Full plus simultaneous pop: at count=4, assert in_valid and out_ready together.
  - Pop occurs and push does not; count goes to 3.
  - The next cycle the push is accepted and count returns to 4.
- Flush priority: at count=2, assert flush, in_valid and out_ready together. Expect count=0 and empty=1 on the next cycle. The next push of 0xDEADBEEF is the first data out.
- Async reset mid-stream: at count=3, pulse clr low between clock edges.
  - Outputs go to reset values immediately, without waiting for an edge.
  - After release, push 0xCAFEF00D: it is read back first, with count=1.

Source files
------------

// File: rtl/fifo4x32_hs_pkg.sv
// fifo4x32_hs_pkg: shared sizing constants for the 4x32 handshake FIFO
package fifo4x32_hs_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;
  localparam int FIFO_CNT_W = 3;
  localparam int FIFO_WIDTH = 32;
  typedef logic [FIFO_PTR_W-1:0] ptr_t;
  typedef logic [FIFO_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/fifo4x32_hs_if.sv
// fifo4x32_hs_if: write/read handshake bundle plus flush and status
// master: flush, in_valid, in_data, out_ready driven; slave: in_ready, out_valid, out_data, count, full, empty driven
interface fifo4x32_hs_if
  import fifo4x32_hs_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  cnt_t             count;
  logic             full;
  logic             empty;
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, full, empty
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, full, empty
  );
endinterface

// File: rtl/fifo4x32_hs_fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, occupancy count, status and write-enable decode
// in: clk, clr (async active-low), i_push, i_pop, i_flush; out: o_rd_ptr, o_count, o_full, o_empty, o_we
module fifo_ptr_ctrl
  import fifo4x32_hs_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output ptr_t                  o_rd_ptr,
  output cnt_t                  o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [FIFO_DEPTH-1:0] o_we
);
  ptr_t r_wr_ptr;
  ptr_t r_rd_ptr;
  cnt_t r_count;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + ptr_t'(i_push);
      r_rd_ptr <= r_rd_ptr + ptr_t'(i_pop);
      r_count  <= r_count + cnt_t'(i_push) - cnt_t'(i_pop);
    end
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_we
    assign o_we[i] = i_push & (r_wr_ptr == ptr_t'(i));
  end
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = r_count == cnt_t'(FIFO_DEPTH);
  assign o_empty  = r_count == '0;
endmodule

// File: rtl/fifo4x32_hs.sv
// fifo4x32_hs: four-entry valid/ready FIFO with flush, no bypass and no full pass-through
// in: clk, clr (async active-low); bus: slave side of fifo4x32_hs_if
module fifo4x32_hs
  import fifo4x32_hs_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input logic          clk,
  input logic          clr,
  fifo4x32_hs_if.slave bus
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_DEPTH-1:0] w_we;
  ptr_t w_rd_ptr;
  cnt_t w_count;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  // status comes only from the count register, so ready/valid never see the far side
  assign w_push = bus.in_valid & ~w_full & ~bus.flush;
  assign w_pop  = bus.out_ready & ~w_empty & ~bus.flush;
  fifo_ptr_ctrl u_ctrl (
    .clk     (clk),
    .clr     (clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .o_rd_ptr(w_rd_ptr),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_we    (w_we)
  );
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    always_ff @(posedge clk)
      if (w_we[i]) r_mem[i] <= bus.in_data;
  end
  assign bus.out_data  = r_mem[w_rd_ptr];
  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.count     = w_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
endmodule

// File: tb/tb_fifo4x32_hs.sv
// tb_fifo4x32_hs: directed scoreboard bench for fifo4x32_hs
module tb_fifo4x32_hs;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  fifo4x32_hs_if #(.WIDTH(32)) bus ();
  fifo4x32_hs dut (.clk(clk), .clr(clr), .bus(bus));
  int n_run = 0;
  int n_fail = 0;
  int m_cnt = 0;
  logic [31:0] q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // packed status {count, full, empty, in_ready, out_valid} against the model occupancy
  task automatic chk_state(input string tag);
    logic [6:0] got, exp;
    got = {bus.count, bus.full, bus.empty, bus.in_ready, bus.out_valid};
    exp = {3'(m_cnt), m_cnt == 4, m_cnt == 0, m_cnt != 4, m_cnt != 0};
    chk({tag, ":state"}, 32'(got), 32'(exp));
  endtask
  task automatic cycle(input string tag);
    logic push, pop;
    push = bus.in_valid && m_cnt < 4 && !bus.flush;
    pop  = bus.out_ready && m_cnt > 0 && !bus.flush;
    if (pop) chk({tag, ":data"}, bus.out_data, q.pop_front());
    if (bus.flush) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (push) q.push_back(bus.in_data);
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask
  initial begin
    bus.flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    #1 clr = 1'b0;
    #1 chk_state("reset");
    #10 clr = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) cycle("idle");
    drive(1'b1, 32'h11111111, 1'b0); cycle("fill1");
    drive(1'b1, 32'h22222222, 1'b0); cycle("fill2");
    drive(1'b1, 32'h33333333, 1'b0); cycle("fill3");
    drive(1'b1, 32'h44444444, 1'b0); cycle("fill4");
    drive(1'b1, 32'h55555555, 1'b0); cycle("fifth");
    drive(1'b0, '0, 1'b1);
    repeat (4) cycle("drain");
    drive(1'b1, 32'hA5A5A5A5, 1'b0); cycle("preload");
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      cycle("wrap");
    end
    drive(1'b0, '0, 1'b1); cycle("wrap_end");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h60000000 + 32'(i), 1'b0);
      cycle("refill");
    end
    drive(1'b1, 32'h66666666, 1'b1); cycle("full_pop");
    drive(1'b1, 32'h66666666, 1'b0); cycle("full_push");
    drive(1'b0, '0, 1'b1);
    repeat (4) cycle("drain2");
    drive(1'b1, 32'h77777777, 1'b0); cycle("pre_fl1");
    drive(1'b1, 32'h88888888, 1'b0); cycle("pre_fl2");
    bus.flush = 1'b1;
    drive(1'b1, 32'h99999999, 1'b1); cycle("flush");
    bus.flush = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 1'b0); cycle("post_fl");
    drive(1'b0, '0, 1'b1); cycle("post_fl_pop");
    drive(1'b1, 32'hA0000001, 1'b0); cycle("pre_rst1");
    drive(1'b1, 32'hA0000002, 1'b0); cycle("pre_rst2");
    drive(1'b1, 32'hA0000003, 1'b0); cycle("pre_rst3");
    drive(1'b0, '0, 1'b0);
    #1 clr = 1'b0;
    q.delete();
    m_cnt = 0;
    #1 chk_state("async_rst");
    #1 clr = 1'b1;
    drive(1'b1, 32'hCAFEF00D, 1'b0); cycle("post_rst");
    drive(1'b0, '0, 1'b1); cycle("post_rst_pop");
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
